mole_ctrl: RTL

//  Whack-a-mole round controller, directly downstream of the 2-bit pseudo-random

---
 rtl/mole_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mole_ctrl.sv
// Whack-a-mole round controller: picks a mole from num, times it on tick, scores presses over ROUNDS rounds.
// Latency: registered outputs respond one cycle after a button edge or expiring tick; no backpressure.
// Optional MOLE_CTRL_PENALTY_EN: a wrong-button press in UP costs one point (floor 0).
module mole_ctrl #(
    parameter int GAP_TICKS  = 2,
    parameter int MOLE_TICKS = 3,
    parameter int ROUNDS     = 16,
    parameter int TIMER_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [1:0] num,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] GAP_INIT   = TIMER_W'(GAP_TICKS);
    localparam logic [TIMER_W-1:0] MOLE_INIT  = TIMER_W'(MOLE_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [7:0]         LAST_ROUND = 8'(ROUNDS - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [7:0]         round;
    logic [1:0]         mole;
    logic [3:0]         btn_q;

    logic [3:0] btn_rise;
    logic [3:0] mole_mask;
    logic       hit;
    logic       expire;
    logic [7:0] score_inc;
    logic [7:0] miss_inc;

    always_comb begin
        btn_rise  = btn & ~btn_q;
        mole_mask = 4'b0001 << mole;
        hit       = |(btn_rise & mole_mask);
        expire    = tick && (timer == TIMER_ONE);
        score_inc = (score == 8'hFF) ? score : score + 8'd1;
        miss_inc  = (misses == 8'hFF) ? misses : misses + 8'd1;
    end

`ifdef MOLE_CTRL_PENALTY_EN
    logic       wrong;
    logic [7:0] score_dec;

    always_comb begin
        wrong     = |(btn_rise & ~mole_mask);
        score_dec = (score == 8'd0) ? score : score - 8'd1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            round     <= '0;
            mole      <= '0;
            btn_q     <= '0;
            led       <= '0;
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
        end else begin
            btn_q <= btn;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score     <= '0;
                        misses    <= '0;
                        round     <= '0;
                        timer     <= GAP_INIT;
                        game_over <= 1'b0;
                        led       <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    led <= '0;
                    if (tick) begin
                        if (timer == TIMER_ONE) begin
                            mole  <= num;
                            led   <= 4'b0001 << num;
                            timer <= MOLE_INIT;
                            state <= UP;
                        end else begin
                            timer <= timer - TIMER_ONE;
                        end
                    end
                end
                UP: begin
`ifdef MOLE_CTRL_PENALTY_EN
                    // A correct hit in the same cycle masks any wrong press.
                    if (!hit && wrong) begin
                        score <= score_dec;
                    end
`endif
                    if (hit || expire) begin
                        led <= '0;
                        if (hit) begin
                            score <= score_inc;
                        end else begin
                            misses <= miss_inc;
                        end
                        if (round == LAST_ROUND) begin
                            game_over <= 1'b1;
                            state     <= DONE;
                        end else begin
                            round <= round + 8'd1;
                            timer <= GAP_INIT;
                            state <= GAP;
                        end
                    end else if (tick) begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
